tx_os_sched: RTL and testbench

- Transmit ordered-set scheduler between the TS generator and the per-lane TX FIFO.
- Per cycle it picks one 128-bit (16-symbol) block to send: EIOS, SKP, a TS1/TS2 from the generator, or logical idle.
- Inserts SKP blocks at a fixed block interval and sequences electrical-idle entry and exit.
- Gives the TS generator a full/backpressure signal through a 2-entry TS buffer, which absorbs the generator's one-cycle valid lag.

---
 rtl/tx_os_sched_if.sv | 28 ++
 rtl/tx_os_sched.sv | 163 ++++++++++++++++
 tb/tb_tx_os_sched.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_os_sched_if.sv
// Bundle between the TS generator / FSM side and the ordered-set scheduler.
// The master modport is the driving side; the scheduler uses the slave modport.
interface tx_os_sched_if;
  logic         speed;
  logic         tx_en;
  logic         idle_en;
  logic         eios_req;
  logic         eidle_exit;
  logic         ts_valid;
  logic [127:0] ts;
  logic         ts_tx_fifo_full;
  logic         tx_fifo_full;
  logic         os_valid;
  logic [127:0] os_data;
  logic [1:0]   os_type;
  logic         eios_done;
  logic [15:0]  skp_cnt;

  modport master (
    output speed, tx_en, idle_en, eios_req, eidle_exit, ts_valid, ts, tx_fifo_full,
    input  ts_tx_fifo_full, os_valid, os_data, os_type, eios_done, skp_cnt
  );

  modport slave (
    input  speed, tx_en, idle_en, eios_req, eidle_exit, ts_valid, ts, tx_fifo_full,
    output ts_tx_fifo_full, os_valid, os_data, os_type, eios_done, skp_cnt
  );
endinterface

// File: rtl/tx_os_sched.sv
// Transmit ordered-set scheduler: chooses one 16-symbol block per cycle (EIOS, SKP,
// buffered TS or logical idle), inserts SKP at a fixed block interval and sequences
// electrical-idle entry/exit. A 2-entry TS buffer absorbs the generator's valid lag.
module tx_os_sched #(
  parameter int unsigned SKP_INTERVAL = 74,
  parameter int unsigned CNT_W        = 12
) (
  input logic         clk,
  input logic         rst,
  tx_os_sched_if.slave bus
);

  localparam logic [CNT_W-1:0] SkpWrap = CNT_W'(SKP_INTERVAL - 1);

  localparam logic [127:0] SkpBlk  = {32'hBC1C_1C1C, 96'h0};
  localparam logic [127:0] EiosBlk = {32'hBC7C_7C7C, 96'h0};
  localparam logic [127:0] IdleBlk = 128'h0;

  localparam logic [1:0] TypeTs   = 2'b00;
  localparam logic [1:0] TypeSkp  = 2'b01;
  localparam logic [1:0] TypeEios = 2'b10;
  localparam logic [1:0] TypeIdle = 2'b11;

  typedef enum logic [1:0] {StOff, StActive, StEios, StEidle} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             skp_pending_q;
  logic [1:0]       eios_left_q;
  logic [127:0]     buf_q [2];
  logic [1:0]       buf_cnt_q;

  logic             os_valid_q;
  logic [127:0]     os_data_q;
  logic [1:0]       os_type_q;
  logic             eios_done_q;
  logic [15:0]      skp_cnt_q;

  logic             decide;
  logic             in_active;
  logic             flush;
  logic             pop;
  logic             push;
  logic [CNT_W-1:0] cnt_inc;

  // Buffer control for this cycle; pops and flushes only happen on decision cycles.
  always_comb begin
    decide    = !bus.tx_fifo_full;
    in_active = (state_q == StActive);
    flush     = decide & in_active & (!bus.tx_en | bus.eios_req);
    pop       = decide & in_active & bus.tx_en & !bus.eios_req & !skp_pending_q &
                (buf_cnt_q != 2'd0);
    push      = bus.ts_valid & (buf_cnt_q != 2'd2);
    cnt_inc   = cnt_q + 1'b1;
  end

  assign bus.ts_tx_fifo_full = (buf_cnt_q != 2'd0) | !in_active;
  assign bus.os_valid        = os_valid_q;
  assign bus.os_data         = os_data_q;
  assign bus.os_type         = os_type_q;
  assign bus.eios_done       = eios_done_q;
  assign bus.skp_cnt         = skp_cnt_q;

  // Two-entry TS buffer, head in slot 0; a push into a full buffer is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_cnt_q <= 2'd0;
      buf_q[0]  <= '0;
      buf_q[1]  <= '0;
    end else if (flush) begin
      buf_cnt_q <= 2'd0;
    end else if (push && pop) begin
      // Only reachable with one entry: the new block becomes the head.
      buf_q[0] <= bus.ts;
    end else if (push) begin
      buf_q[buf_cnt_q[0]] <= bus.ts;
      buf_cnt_q           <= buf_cnt_q + 2'd1;
    end else if (pop) begin
      buf_q[0]  <= buf_q[1];
      buf_cnt_q <= buf_cnt_q - 2'd1;
    end
  end

  // Scheduler FSM with registered block outputs; everything holds while downstream is full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StOff;
      cnt_q         <= '0;
      skp_pending_q <= 1'b0;
      eios_left_q   <= 2'd0;
      os_valid_q    <= 1'b0;
      os_data_q     <= '0;
      os_type_q     <= TypeTs;
      eios_done_q   <= 1'b0;
      skp_cnt_q     <= '0;
    end else begin
      os_valid_q  <= 1'b0;
      os_data_q   <= '0;
      os_type_q   <= TypeTs;
      eios_done_q <= 1'b0;
      if (decide) begin
        unique case (state_q)
          StOff: begin
            if (bus.tx_en) begin
              state_q       <= StActive;
              cnt_q         <= '0;
              skp_pending_q <= 1'b0;
            end
          end
          StActive: begin
            if (!bus.tx_en) begin
              state_q <= StOff;
            end else if (bus.eios_req) begin
              state_q       <= StEios;
              skp_pending_q <= 1'b0;
              eios_left_q   <= bus.speed ? 2'd2 : 2'd1;
            end else if (skp_pending_q) begin
              os_valid_q    <= 1'b1;
              os_data_q     <= SkpBlk;
              os_type_q     <= TypeSkp;
              skp_pending_q <= 1'b0;
              cnt_q         <= '0;
              if (skp_cnt_q != 16'hFFFF) skp_cnt_q <= skp_cnt_q + 16'd1;
            end else if ((buf_cnt_q != 2'd0) || bus.idle_en) begin
              os_valid_q <= 1'b1;
              os_data_q  <= (buf_cnt_q != 2'd0) ? buf_q[0] : IdleBlk;
              os_type_q  <= (buf_cnt_q != 2'd0) ? TypeTs : TypeIdle;
              // Counter wraps the moment the interval is reached; SKP goes out next.
              if (cnt_inc == SkpWrap) begin
                cnt_q         <= '0;
                skp_pending_q <= 1'b1;
              end else begin
                cnt_q <= cnt_inc;
              end
            end
          end
          StEios: begin
            if (eios_left_q != 2'd0) begin
              os_valid_q  <= 1'b1;
              os_data_q   <= EiosBlk;
              os_type_q   <= TypeEios;
              eios_left_q <= eios_left_q - 2'd1;
            end else begin
              eios_done_q <= 1'b1;
              state_q     <= StEidle;
            end
          end
          StEidle: begin
            if (!bus.tx_en) begin
              state_q <= StOff;
            end else if (bus.eidle_exit) begin
              state_q       <= StActive;
              cnt_q         <= '0;
              skp_pending_q <= 1'b0;
            end
          end
          default: state_q <= StOff;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tx_os_sched.sv
// Bench for tx_os_sched: queue-based behavioural model checked every cycle, directed
// scenarios with literal expectations, then a randomized run.
module tb_tx_os_sched;
  localparam int SKP_INTERVAL = 74;
  localparam logic [127:0] SkpBlk  = {32'hBC1C_1C1C, 96'h0};
  localparam logic [127:0] EiosBlk = {32'hBC7C_7C7C, 96'h0};
  localparam logic [127:0] TsConst = {40'hBCF7F7FF02, 8'h00, {10{8'h4A}}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tx_os_sched_if ifc ();

  tx_os_sched #(.SKP_INTERVAL(SKP_INTERVAL), .CNT_W(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int tests = 0;
  int fails = 0;

  // Model: mode 0 off, 1 active, 2 sending EIOS, 3 electrical idle.
  int           m_mode;
  int           m_since;     // non-SKP blocks since last SKP or ACTIVE entry
  int           m_eios_left;
  int           m_drops;
  logic [15:0]  m_skp;
  logic [127:0] m_q[$];
  logic         exp_valid, exp_done;
  logic [127:0] exp_data;
  logic [1:0]   exp_type;

  logic gen_on = 1'b0;
  logic gen_const = 1'b0;
  logic chk_en = 1'b0;

  // Observation counters fed by the compare process.
  int           idle_ct, eios_ct, done_ct;
  logic         seen_skp;
  logic [127:0] skp_seen_data, eios_seen_data;
  logic [15:0]  skp_seen_cnt;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_since = 0; m_eios_left = 0; m_skp = '0;
    m_q.delete();
    exp_valid = 0; exp_done = 0; exp_data = '0; exp_type = 2'b00;
  endtask

  task automatic emit(input logic [127:0] d, input logic [1:0] ty);
    exp_valid = 1; exp_data = d; exp_type = ty;
  endtask

  // Advance the model across one clock edge using the inputs present at that edge.
  task automatic model_step();
    logic         push_ok, flushed;
    logic [127:0] t;
    if (rst) begin
      model_reset();
      return;
    end
    exp_valid = 0; exp_done = 0; exp_data = '0; exp_type = 2'b00;
    t       = ifc.ts;
    flushed = 0;
    push_ok = ifc.ts_valid && (m_q.size() < 2);
    if (ifc.ts_valid && m_q.size() == 2) m_drops++;
    if (!ifc.tx_fifo_full) begin
      case (m_mode)
        0: if (ifc.tx_en) begin m_mode = 1; m_since = 0; end
        1: begin
          if (!ifc.tx_en) begin
            m_mode = 0; flushed = 1;
          end else if (ifc.eios_req) begin
            m_mode = 2; m_eios_left = ifc.speed ? 2 : 1; flushed = 1;
          end else if (m_since == SKP_INTERVAL - 1) begin
            emit(SkpBlk, 2'b01); m_since = 0;
            if (m_skp != 16'hFFFF) m_skp++;
          end else if (m_q.size() > 0) begin
            emit(m_q.pop_front(), 2'b00); m_since++;
          end else if (ifc.idle_en) begin
            emit(128'h0, 2'b11); m_since++;
          end
        end
        2: begin
          if (m_eios_left > 0) begin
            emit(EiosBlk, 2'b10); m_eios_left--;
          end else begin
            exp_done = 1; m_mode = 3;
          end
        end
        default: begin
          if (!ifc.tx_en) m_mode = 0;
          else if (ifc.eidle_exit) begin m_mode = 1; m_since = 0; end
        end
      endcase
    end
    if (flushed) m_q.delete();
    else if (push_ok) m_q.push_back(t);
  endtask

  // One clock: model steps over the edge, then the generator reacts with one cycle of lag.
  task automatic step_cycle();
    logic full_pre;
    full_pre = ifc.ts_tx_fifo_full;
    @(posedge clk);
    #2;
    model_step();
    ifc.ts_valid = gen_on && !full_pre;
    if (gen_const) ifc.ts = TsConst;
    else ifc.ts = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Compare process: DUT against model every cycle, away from the clock edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("os_valid", 128'(ifc.os_valid), 128'(exp_valid));
      check("ts_tx_fifo_full", 128'(ifc.ts_tx_fifo_full),
            128'((m_q.size() >= 1) || (m_mode != 1)));
      check("eios_done", 128'(ifc.eios_done), 128'(exp_done));
      check("skp_cnt", 128'(ifc.skp_cnt), 128'(m_skp));
      if (exp_valid) begin
        check("os_type", 128'(ifc.os_type), 128'(exp_type));
        check("os_data", ifc.os_data, exp_data);
      end
      if (ifc.os_valid && ifc.os_type == 2'b11 && !seen_skp) idle_ct++;
      if (ifc.os_valid && ifc.os_type == 2'b01 && !seen_skp) begin
        seen_skp = 1; skp_seen_data = ifc.os_data; skp_seen_cnt = ifc.skp_cnt;
      end
      if (ifc.os_valid && ifc.os_type == 2'b10) begin
        eios_ct++; eios_seen_data = ifc.os_data;
      end
      if (ifc.eios_done) done_ct++;
    end
  end

  initial begin
    logic found;
    ifc.speed = 0; ifc.tx_en = 0; ifc.idle_en = 0; ifc.eios_req = 0; ifc.eidle_exit = 0;
    ifc.ts_valid = 0; ifc.ts = '0; ifc.tx_fifo_full = 0;
    m_drops = 0; idle_ct = 0; eios_ct = 0; done_ct = 0; seen_skp = 0;
    skp_seen_data = '0; eios_seen_data = '0; skp_seen_cnt = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check("reset os_valid", 128'(ifc.os_valid), 128'(0));
    check("reset os_data", ifc.os_data, 128'h0);
    check("reset ts_tx_fifo_full", 128'(ifc.ts_tx_fifo_full), 128'(1));
    check("reset skp_cnt", 128'(ifc.skp_cnt), 128'(0));
    rst = 0;
    chk_en = 1;

    // Idle stream: 73 IDLE blocks, then the first SKP.
    ifc.tx_en = 1; ifc.idle_en = 1;
    repeat (80) step_cycle();
    check("idle blocks before skp", 128'(idle_ct), 128'(73));
    check("first skp data", skp_seen_data, SkpBlk);
    check("first skp count", 128'(skp_seen_cnt), 128'(1));

    // Constant TS stream with a 5-cycle downstream stall in the middle.
    gen_on = 1; gen_const = 1;
    repeat (100) step_cycle();
    ifc.tx_fifo_full = 1;
    repeat (5) step_cycle();
    ifc.tx_fifo_full = 0;
    repeat (100) step_cycle();
    gen_on = 0; gen_const = 0;
    repeat (4) step_cycle();

    // EIOS request right after SKP becomes pending, Gen2.
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      step_cycle();
      if (m_mode == 1 && m_since == SKP_INTERVAL - 1) found = 1;
    end
    check("skp pending reached", 128'(found), 128'(1));
    eios_ct = 0; done_ct = 0;
    ifc.speed = 1; ifc.eios_req = 1;
    step_cycle();
    ifc.eios_req = 0;
    repeat (8) step_cycle();
    check("gen2 eios blocks", 128'(eios_ct), 128'(2));
    check("eios data", eios_seen_data, EiosBlk);
    check("eios_done pulses", 128'(done_ct), 128'(1));
    idle_ct = 0; seen_skp = 0;
    ifc.eidle_exit = 1;
    step_cycle();
    ifc.eidle_exit = 0;
    repeat (80) step_cycle();
    check("idle blocks after exit", 128'(idle_ct), 128'(73));

    // Gen1 EIOS, then leave via tx_en=0 from electrical idle.
    eios_ct = 0;
    ifc.speed = 0; ifc.eios_req = 1;
    step_cycle();
    ifc.eios_req = 0;
    repeat (6) step_cycle();
    check("gen1 eios blocks", 128'(eios_ct), 128'(1));
    ifc.tx_en = 0;
    repeat (2) step_cycle();
    check("off ts_tx_fifo_full", 128'(ifc.ts_tx_fifo_full), 128'(1));

    // Async reset with one of two EIOS blocks out.
    ifc.tx_en = 1;
    repeat (3) step_cycle();
    ifc.speed = 1; ifc.eios_req = 1;
    step_cycle();
    ifc.eios_req = 0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step_cycle();
      if (exp_valid && exp_type == 2'b10) found = 1;
    end
    check("first eios reached", 128'(found), 128'(1));
    #1;
    rst = 1;
    model_reset();
    #1;
    check("mid reset os_valid", 128'(ifc.os_valid), 128'(0));
    check("mid reset os_data", ifc.os_data, 128'h0);
    check("mid reset os_type", 128'(ifc.os_type), 128'(0));
    check("mid reset ts_tx_fifo_full", 128'(ifc.ts_tx_fifo_full), 128'(1));
    check("mid reset skp_cnt", 128'(ifc.skp_cnt), 128'(0));
    repeat (2) step_cycle();
    rst = 0;
    eios_ct = 0;
    repeat (20) step_cycle();
    check("no eios after reset", 128'(eios_ct), 128'(0));

    // Randomized traffic.
    gen_on = 1;
    for (int i = 0; i < 4000; i++) begin
      ifc.tx_fifo_full = ($urandom_range(0, 7) == 0);
      ifc.eios_req     = ($urandom_range(0, 199) == 0);
      ifc.eidle_exit   = ($urandom_range(0, 15) == 0);
      ifc.speed        = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 299) == 0) ifc.tx_en = 0;
      else if (!ifc.tx_en && $urandom_range(0, 9) == 0) ifc.tx_en = 1;
      if (i % 256 == 0) begin
        ifc.idle_en = 1'($urandom_range(0, 1));
        gen_on      = ($urandom_range(0, 3) != 0);
      end
      step_cycle();
    end
    ifc.eios_req = 0; ifc.eidle_exit = 0;
    step_cycle();
    @(negedge clk);
    check("ts buffer drops", 128'(m_drops), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
